// File: rtl/xadc_drp_scheduler.sv
// Round-robin sequencer sharing the single XADC DRP read port among NUM_REQ requesters.
// One read in flight at a time; a missing drdy is recovered by a saturating timeout.
module xadc_drp_scheduler #(
   parameter int NUM_REQ     = 3,
   parameter int TIMEOUT_CYC = 64,
   parameter int TO_W        = 7
) (
   input  logic                 clk_1MHz,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   i_req,
   input  logic [7*NUM_REQ-1:0] i_req_addr,
   output logic [NUM_REQ-1:0]   o_rsp_valid,
   output logic [15:0]          o_rsp_data,
   output logic                 o_rsp_err,
   output logic                 o_busy,
   output logic [6:0]           o_drp_daddr,
   output logic                 o_drp_den,
   output logic                 o_drp_dwe,
   output logic [15:0]          o_drp_di,
   input  logic [15:0]          i_drp_do,
   input  logic                 i_drp_drdy
);
   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t               r_state, w_state_nxt;
   logic [IDX_W-1:0]     r_gnt, w_gnt_nxt;
   logic [IDX_W-1:0]     r_rr_ptr, w_rr_nxt;
   logic [6:0]           r_daddr, w_daddr_nxt;
   logic                 r_den, w_den_nxt;
   logic                 r_busy, w_busy_nxt;
   logic [NUM_REQ-1:0]   r_rsp_valid, w_rsp_valid_nxt;
   logic [15:0]          r_rsp_data, w_rsp_data_nxt;
   logic                 r_rsp_err, w_rsp_err_nxt;
   logic [TO_W-1:0]      r_cnt, w_cnt_nxt;

   logic                 w_any;
   logic [IDX_W-1:0]     w_idx;
   logic [IDX_W-1:0]     w_sel;
   logic [6:0]           w_sel_addr;

   // Search upward from the requester after the last grant, wrapping at NUM_REQ.
   always_comb begin
      w_any = 1'b0;
      w_sel = '0;
      w_idx = r_rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
         if (!w_any && i_req[w_idx]) begin
            w_any = 1'b1;
            w_sel = w_idx;
         end
      end
   end

   always_comb begin
      w_sel_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_sel == IDX_W'(i)) begin
            w_sel_addr = i_req_addr[7*i +: 7];
         end
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_gnt_nxt       = r_gnt;
      w_rr_nxt        = r_rr_ptr;
      w_daddr_nxt     = r_daddr;
      w_den_nxt       = 1'b0;
      w_busy_nxt      = r_busy;
      w_rsp_valid_nxt = '0;
      w_rsp_data_nxt  = r_rsp_data;
      w_rsp_err_nxt   = 1'b0;
      w_cnt_nxt       = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_gnt_nxt   = w_sel;
               w_daddr_nxt = w_sel_addr;
               w_den_nxt   = 1'b1;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // Data arriving on the expiry cycle still counts as a good read.
            if (i_drp_drdy) begin
               w_rsp_data_nxt  = i_drp_do;
               w_rsp_valid_nxt = NUM_REQ'(1) << r_gnt;
               w_state_nxt     = S_RESP;
            end else if (r_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
               w_rsp_data_nxt  = '0;
               w_rsp_err_nxt   = 1'b1;
               w_rsp_valid_nxt = NUM_REQ'(1) << r_gnt;
               w_state_nxt     = S_RESP;
            end else if (r_cnt != '1) begin
               w_cnt_nxt = r_cnt + TO_W'(1);
            end
         end
         S_RESP: begin
            w_rr_nxt    = r_gnt;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_gnt       <= '0;
         r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
         r_daddr     <= '0;
         r_den       <= 1'b0;
         r_busy      <= 1'b0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_gnt       <= w_gnt_nxt;
         r_rr_ptr    <= w_rr_nxt;
         r_daddr     <= w_daddr_nxt;
         r_den       <= w_den_nxt;
         r_busy      <= w_busy_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_data  <= w_rsp_data_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_cnt       <= w_cnt_nxt;
      end
   end

   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_data  = r_rsp_data;
   assign o_rsp_err   = r_rsp_err;
   assign o_busy      = r_busy;
   assign o_drp_daddr = r_daddr;
   assign o_drp_den   = r_den;
   assign o_drp_dwe   = 1'b0;
   assign o_drp_di    = 16'h0000;

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Bench for xadc_drp_scheduler: a cycle-stamped transaction model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_xadc_drp_scheduler;
   localparam int NUM_REQ     = 3;
   localparam int TIMEOUT_CYC = 64;
   localparam int TO_W        = 7;

   logic                 clk_1MHz   = 1'b0;
   logic                 rst_n      = 1'b1;
   logic [NUM_REQ-1:0]   i_req      = '0;
   logic [7*NUM_REQ-1:0] i_req_addr = '0;
   logic [15:0]          i_drp_do   = '0;
   logic                 i_drp_drdy = 1'b0;
   logic [NUM_REQ-1:0]   o_rsp_valid;
   logic [15:0]          o_rsp_data;
   logic                 o_rsp_err;
   logic                 o_busy;
   logic [6:0]           o_drp_daddr;
   logic                 o_drp_den;
   logic                 o_drp_dwe;
   logic [15:0]          o_drp_di;

   int checks = 0;
   int errors = 0;
   int tb_cyc = 0;

   xadc_drp_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) dut (
      .clk_1MHz    (clk_1MHz),
      .rst_n       (rst_n),
      .i_req       (i_req),
      .i_req_addr  (i_req_addr),
      .o_rsp_valid (o_rsp_valid),
      .o_rsp_data  (o_rsp_data),
      .o_rsp_err   (o_rsp_err),
      .o_busy      (o_busy),
      .o_drp_daddr (o_drp_daddr),
      .o_drp_den   (o_drp_den),
      .o_drp_dwe   (o_drp_dwe),
      .o_drp_di    (o_drp_di),
      .i_drp_do    (i_drp_do),
      .i_drp_drdy  (i_drp_drdy)
   );

   always #500 clk_1MHz = ~clk_1MHz;
   always @(posedge clk_1MHz) tb_cyc <= tb_cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, tb_cyc);
      end
   endtask

   // Transaction model: each grant is stamped with its den cycle and response cycle.
   int                 mc = 0, m_last = NUM_REQ - 1, m_gnt = 0, m_den_at = -1, m_rsp_at = -1;
   bit                 m_busy = 1'b0, m_found;
   logic [NUM_REQ-1:0] m_tmp;
   logic [6:0]         m_addr = '0;
   logic [15:0]        m_data = '0;
   logic               m_err = 1'b0;
   logic               e_busy = 1'b0, e_den = 1'b0, e_err = 1'b0;
   logic [NUM_REQ-1:0] e_valid = '0;
   logic [6:0]         e_daddr = '0;
   logic [15:0]        e_data = '0;

   always @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_last = NUM_REQ - 1; m_gnt = 0; m_den_at = -1; m_rsp_at = -1;
         m_addr = '0; m_data = '0; m_err = 1'b0;
         e_busy = 1'b0; e_den = 1'b0; e_valid = '0; e_daddr = '0; e_data = '0; e_err = 1'b0;
      end else begin
         if (m_busy && mc == m_rsp_at) begin
            m_busy = 1'b0;
            m_last = m_gnt;
         end else if (m_busy && m_rsp_at < 0 && mc > m_den_at) begin
            if (i_drp_drdy) begin
               m_rsp_at = mc + 1; m_data = i_drp_do; m_err = 1'b0;
            end else if (mc - m_den_at - 1 == TIMEOUT_CYC - 1) begin
               m_rsp_at = mc + 1; m_data = 16'h0000; m_err = 1'b1;
            end
         end else if (!m_busy && i_req != '0) begin
            m_found = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
               m_tmp = i_req >> ((m_last + k) % NUM_REQ);
               if (!m_found && m_tmp[0]) begin
                  m_found = 1'b1;
                  m_gnt = (m_last + k) % NUM_REQ;
               end
            end
            m_busy = 1'b1; m_den_at = mc + 1; m_rsp_at = -1;
            m_addr = 7'(i_req_addr >> (7 * m_gnt));
         end
         e_busy  = m_busy;
         e_den   = m_busy && (m_den_at == mc + 1);
         e_valid = (m_busy && m_rsp_at == mc + 1) ? (NUM_REQ'(1) << m_gnt) : '0;
         e_daddr = m_addr;
         e_data  = m_data;
         e_err   = m_err;
         mc++;
      end
   end

   always @(negedge clk_1MHz) begin
      chk("m_busy", 32'(o_busy), 32'(e_busy));
      chk("m_den", 32'(o_drp_den), 32'(e_den));
      chk("m_daddr", 32'(o_drp_daddr), 32'(e_daddr));
      chk("m_valid", 32'(o_rsp_valid), 32'(e_valid));
      chk("m_dwe_di", {15'd0, o_drp_dwe, o_drp_di}, 32'd0);
      if (e_valid != '0) begin
         chk("m_data", 32'(o_rsp_data), 32'(e_data));
         chk("m_err", 32'(o_rsp_err), 32'(e_err));
      end
   end

   task automatic wait_den(output int c);
      c = -1;
      for (int n = 0; n < 20; n++) begin
         if (o_drp_den) begin c = tb_cyc; break; end
         @(negedge clk_1MHz);
      end
      if (c < 0) begin checks++; errors++; $display("FAIL wait_den: no den within 20 cycles"); end
   endtask

   task automatic wait_rsp(output int c);
      c = -1;
      for (int n = 0; n < 200; n++) begin
         if (o_rsp_valid != '0) begin c = tb_cyc; break; end
         @(negedge clk_1MHz);
      end
      if (c < 0) begin checks++; errors++; $display("FAIL wait_rsp: no response within 200 cycles"); end
   endtask

   task automatic pulse_drdy(input logic [15:0] d);
      i_drp_drdy = 1'b1; i_drp_do = d;
      @(negedge clk_1MHz);
      i_drp_drdy = 1'b0; i_drp_do = 16'h0000;
   endtask

   task automatic set_addrs(input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2);
      i_req_addr = {a2, a1, a0};
   endtask

   function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
      int idx = -1;
      int cnt = 0;
      logic [NUM_REQ-1:0] t;
      for (int i = 0; i < NUM_REQ; i++) begin
         t = v >> i;
         if (t[0]) begin idx = i; cnt++; end
      end
      return (cnt == 1) ? idx : -1;
   endfunction

   task automatic check_all_zero(input string nm);
      chk(nm, {o_busy, o_drp_den, o_rsp_err, o_drp_daddr, o_rsp_valid}, 32'd0);
      chk(nm, 32'(o_rsp_data), 32'd0);
   endtask

   int e, r;
   int g[6];
   logic [6:0] da[6];
   logic [6:0] rr_addr[3] = '{7'h16, 7'h17, 7'h00};

   initial begin
      #5 rst_n = 1'b0;
      #5 check_all_zero("reset_outputs");
      repeat (3) @(negedge clk_1MHz);
      rst_n = 1'b1;
      set_addrs(7'h16, 7'h17, 7'h00);
      @(negedge clk_1MHz);

      // Single request, drdy two cycles after den.
      i_req = 3'b001;
      wait_den(e);
      chk("single_daddr", 32'(o_drp_daddr), 32'h16);
      @(negedge clk_1MHz);
      chk("single_den_1cyc", 32'(o_drp_den), 32'd0);
      @(negedge clk_1MHz);
      pulse_drdy(16'hA5C0);
      wait_rsp(r);
      chk("single_valid", 32'(o_rsp_valid), 32'b001);
      chk("single_data", 32'(o_rsp_data), 32'hA5C0);
      chk("single_err", 32'(o_rsp_err), 32'd0);
      chk("single_lat", 32'(r - e), 32'd3);
      i_req = '0;

      // Timeout: den at E, response at E+TIMEOUT_CYC+1 (TIMEOUT_CYC+2 cycles inclusive).
      i_req = 3'b010;
      wait_den(e);
      wait_rsp(r);
      chk("to_valid", 32'(o_rsp_valid), 32'b010);
      chk("to_err", 32'(o_rsp_err), 32'd1);
      chk("to_data", 32'(o_rsp_data), 32'd0);
      chk("to_lat", 32'(r - e), 32'(TIMEOUT_CYC + 1));
      i_req = '0;
      @(negedge clk_1MHz);
      pulse_drdy(16'hFFFF);
      chk("late_drdy_busy", 32'(o_busy), 32'd0);
      repeat (3) begin
         @(negedge clk_1MHz);
         chk("late_drdy_valid", 32'(o_rsp_valid), 32'd0);
      end

      // Request dropped and address changed while waiting.
      i_req = 3'b001;
      wait_den(e);
      @(negedge clk_1MHz);
      i_req = '0;
      set_addrs(7'h55, 7'h17, 7'h00);
      @(negedge clk_1MHz);
      pulse_drdy(16'hBEEF);
      wait_rsp(r);
      chk("drop_daddr", 32'(o_drp_daddr), 32'h16);
      chk("drop_valid", 32'(o_rsp_valid), 32'b001);
      chk("drop_data", 32'(o_rsp_data), 32'hBEEF);
      set_addrs(7'h16, 7'h17, 7'h00);
      @(negedge clk_1MHz);

      // drdy on the very cycle the timeout expires.
      i_req = 3'b100;
      wait_den(e);
      repeat (TIMEOUT_CYC) @(negedge clk_1MHz);
      pulse_drdy(16'h1234);
      wait_rsp(r);
      chk("coin_valid", 32'(o_rsp_valid), 32'b100);
      chk("coin_data", 32'(o_rsp_data), 32'h1234);
      chk("coin_err", 32'(o_rsp_err), 32'd0);
      chk("coin_lat", 32'(r - e), 32'(TIMEOUT_CYC + 1));
      i_req = '0;
      @(negedge clk_1MHz);

      // Reset while waiting, then a stray drdy after release.
      i_req = 3'b010;
      wait_den(e);
      @(negedge clk_1MHz);
      #200 rst_n = 1'b0;
      i_req = '0;
      #1 check_all_zero("midwait_reset");
      @(negedge clk_1MHz);
      rst_n = 1'b1;
      pulse_drdy(16'hDEAD);
      chk("post_reset_valid", 32'(o_rsp_valid), 32'd0);

      // All requesters held: grants rotate starting at 0.
      i_req = 3'b111;
      for (int n = 0; n < 6; n++) begin
         wait_den(e);
         da[n] = o_drp_daddr;
         @(negedge clk_1MHz);
         pulse_drdy(16'h1000 + 16'(n));
         wait_rsp(r);
         g[n] = onehot_idx(o_rsp_valid);
         chk("rr_data", 32'(o_rsp_data), 32'h1000 + 32'(n));
      end
      i_req = '0;
      for (int n = 0; n < 6; n++) begin
         chk("rr_gnt", 32'(g[n]), 32'(n % 3));
         chk("rr_daddr", 32'(da[n]), 32'(rr_addr[n % 3]));
      end
      repeat (4) @(negedge clk_1MHz);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
